// File: rtl/riscv_csr_cnt.sv
// Machine scratch register plus 64-bit cycle/instret counters with a zero-latency CSR read port.
// Define RV_CSR_MCOUNTINHIBIT_EN to add mcountinhibit (0x320) with the CY and IR freeze bits.
module riscv_csr_cnt #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [11:0]     id_csr_reg_i,
    output logic [XLEN-1:0] st_csr_rval_o,
    output logic            st_csr_illegal_o,
    input  logic [11:0]     ex_csr_reg_i,
    input  logic [XLEN-1:0] ex_csr_wval_i,
    input  logic            ex_csr_we_i,
    input  logic            wb_retire_i
);

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    localparam bit RV32 = (XLEN == 32);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("riscv_csr_cnt: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] mscratch_q;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;
    logic [63:0]     cy_lo_val, cy_hi_val, ir_lo_val, ir_hi_val;
    logic            wr_scratch, wr_cy_lo, wr_cy_hi, wr_ir_lo, wr_ir_hi;
    logic            inh_cy, inh_ir;
    logic            fwd;
    logic [XLEN-1:0] fwd_val;
    logic [XLEN-1:0] rval;
    logic            illegal;

`ifdef RV_CSR_MCOUNTINHIBIT_EN
    logic inh_cy_q, inh_ir_q;
    logic wr_inh;
`endif

    // Write decode; read-only ([11:10]=11) and unknown addresses raise no strobe at all.
    always_comb begin
        wr_scratch = 1'b0;
        wr_cy_lo   = 1'b0;
        wr_cy_hi   = 1'b0;
        wr_ir_lo   = 1'b0;
        wr_ir_hi   = 1'b0;
`ifdef RV_CSR_MCOUNTINHIBIT_EN
        wr_inh     = 1'b0;
`endif
        if (ex_csr_we_i && ex_csr_reg_i[11:10] != 2'b11) begin
            case (ex_csr_reg_i)
                CSR_MSCRATCH:      wr_scratch = 1'b1;
                CSR_MCYCLE:        wr_cy_lo   = 1'b1;
                CSR_MINSTRET:      wr_ir_lo   = 1'b1;
                CSR_MCYCLEH:       wr_cy_hi   = RV32;
                CSR_MINSTRETH:     wr_ir_hi   = RV32;
`ifdef RV_CSR_MCOUNTINHIBIT_EN
                CSR_MCOUNTINHIBIT: wr_inh     = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    if (XLEN == 32) begin : g_rv32
        assign cy_lo_val = {mcycle_q[63:32], ex_csr_wval_i};
        assign cy_hi_val = {ex_csr_wval_i, mcycle_q[31:0]};
        assign ir_lo_val = {minstret_q[63:32], ex_csr_wval_i};
        assign ir_hi_val = {ex_csr_wval_i, minstret_q[31:0]};
    end else begin : g_rv64
        // High-half strobes are never raised for XLEN=64.
        assign cy_lo_val = ex_csr_wval_i;
        assign cy_hi_val = mcycle_q;
        assign ir_lo_val = ex_csr_wval_i;
        assign ir_hi_val = minstret_q;
    end

`ifdef RV_CSR_MCOUNTINHIBIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inh_cy_q <= 1'b0;
            inh_ir_q <= 1'b0;
        end else if (wr_inh) begin
            inh_cy_q <= ex_csr_wval_i[0];
            inh_ir_q <= ex_csr_wval_i[2];
        end
    end
    assign inh_cy = inh_cy_q;
    assign inh_ir = inh_ir_q;
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    // Any write to a counter, even a half, replaces the whole increment for that cycle.
    always_comb begin
        mcycle_d = mcycle_q;
        if (wr_cy_lo)         mcycle_d = cy_lo_val;
        else if (wr_cy_hi)    mcycle_d = cy_hi_val;
        else if (!inh_cy)     mcycle_d = mcycle_q + 64'd1;

        minstret_d = minstret_q;
        if (wr_ir_lo)                     minstret_d = ir_lo_val;
        else if (wr_ir_hi)                minstret_d = ir_hi_val;
        else if (wb_retire_i && !inh_ir)  minstret_d = minstret_q + 64'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mscratch_q <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_scratch) mscratch_q <= ex_csr_wval_i;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Forward only writes that will actually land, so ignored writes never leak onto the read port.
    always_comb begin
        fwd     = (wr_scratch | wr_cy_lo | wr_cy_hi | wr_ir_lo | wr_ir_hi)
                  && (ex_csr_reg_i == id_csr_reg_i);
        fwd_val = ex_csr_wval_i;
`ifdef RV_CSR_MCOUNTINHIBIT_EN
        if (wr_inh && ex_csr_reg_i == id_csr_reg_i) begin
            fwd     = 1'b1;
            fwd_val = XLEN'({ex_csr_wval_i[2], 1'b0, ex_csr_wval_i[0]});
        end
`endif
    end

    always_comb begin
        rval    = '0;
        illegal = 1'b0;
        case (id_csr_reg_i)
            CSR_MSCRATCH:              rval = mscratch_q;
            CSR_MCYCLE, CSR_CYCLE:     rval = mcycle_q[XLEN-1:0];
            CSR_MINSTRET, CSR_INSTRET: rval = minstret_q[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: begin
                if (RV32) rval = XLEN'(mcycle_q[63:32]);
                else      illegal = 1'b1;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                if (RV32) rval = XLEN'(minstret_q[63:32]);
                else      illegal = 1'b1;
            end
`ifdef RV_CSR_MCOUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT:         rval = XLEN'({inh_ir, 1'b0, inh_cy});
`endif
            default:                   illegal = 1'b1;
        endcase
        if (fwd) rval = fwd_val;
    end

    assign st_csr_rval_o    = rval;
    assign st_csr_illegal_o = illegal;

endmodule
